// File: rtl/sysid_checker.sv
// Boot-time system-ID check: reads ID (addr 0) and timestamp (addr 1) over Avalon-MM, compares, latches pass/fail.
// Latency: START_DELAY + 3 edges to result with a zero-wait slave, +1 per stall cycle, +READ_LATENCY per word.
// Backpressure: m_read/m_address held while m_waitrequest is high; TIMEOUT stalled cycles abort and retry.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd17734393,
    parameter logic [31:0] EXPECTED_TS  = 32'd1318966812,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter int          MAX_RETRIES  = 3,
    parameter int          START_DELAY  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [3:0]  retries,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    typedef enum logic [2:0] {
        DELAY, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, ABORT, DONE
    } state_t;

    // One counter serves the start delay, the stall timeout and the read-latency wait,
    // since only one of them is ever active in a given state.
    localparam logic [9:0] DLY_LAST = 10'(START_DELAY - 1);
    localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [9:0] LAT_LAST = 10'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [3:0] MAXR     = 4'(MAX_RETRIES);

    state_t     state;
    logic [9:0] cnt;

    // Sequencer: all outputs are registered and updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DELAY;
            cnt         <= '0;
            m_read      <= 1'b0;
            m_address   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 2'd0;
            retries     <= 4'd0;
            captured_id <= '0;
            captured_ts <= '0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DLY_LAST) begin
                        cnt       <= '0;
                        state     <= RD_ID;
                        m_read    <= 1'b1;
                        m_address <= 1'b0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                RD_ID: begin
                    // Acceptance is tested first so it wins over a simultaneous timeout.
                    if (!m_waitrequest) begin
                        cnt <= '0;
                        if (READ_LATENCY == 0) begin
                            captured_id <= m_readdata;
                            state       <= RD_TS;
                            m_address   <= 1'b1;
                        end else begin
                            state  <= WAIT_ID;
                            m_read <= 1'b0;
                        end
                    end else if (cnt == TO_LAST) begin
                        cnt    <= '0;
                        state  <= ABORT;
                        m_read <= 1'b0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                WAIT_ID: begin
                    if (cnt == LAT_LAST) begin
                        cnt         <= '0;
                        captured_id <= m_readdata;
                        state       <= RD_TS;
                        m_read      <= 1'b1;
                        m_address   <= 1'b1;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                RD_TS: begin
                    if (!m_waitrequest) begin
                        cnt    <= '0;
                        m_read <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            captured_ts <= m_readdata;
                            state       <= CHECK;
                        end else begin
                            state <= WAIT_TS;
                        end
                    end else if (cnt == TO_LAST) begin
                        cnt    <= '0;
                        state  <= ABORT;
                        m_read <= 1'b0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                WAIT_TS: begin
                    if (cnt == LAT_LAST) begin
                        cnt         <= '0;
                        captured_ts <= m_readdata;
                        state       <= CHECK;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                CHECK: begin
                    // ID mismatch takes priority over timestamp mismatch.
                    if (captured_id != EXPECTED_ID) begin
                        fail_code <= 2'd1;
                        pass      <= 1'b0;
                    end else if (captured_ts != EXPECTED_TS) begin
                        fail_code <= 2'd2;
                        pass      <= 1'b0;
                    end else begin
                        fail_code <= 2'd0;
                        pass      <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                ABORT: begin
                    // A retry re-reads both words so ID and timestamp come from the same attempt.
                    if (retries < MAXR) begin
                        retries   <= retries + 4'd1;
                        state     <= RD_ID;
                        m_read    <= 1'b1;
                        m_address <= 1'b0;
                    end else begin
                        fail_code <= 2'd3;
                        pass      <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // A rerun skips the power-up delay; the slave is known to be alive.
                    if (start) begin
                        cnt       <= '0;
                        state     <= RD_ID;
                        m_read    <= 1'b1;
                        m_address <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_code <= 2'd0;
                        retries   <= 4'd0;
                    end
                end
                default: state <= DELAY;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: directed scenarios against an edge-arithmetic model of the boot sequence.
// Two instances: defaults (zero-latency slave, scripted stalls) and READ_LATENCY=2 (pipelined slave).
// Outputs are checked 1 time unit after every rising edge and at hand-picked edges with literal values.
module tb_sysid_checker;

    localparam logic [31:0] EID  = 32'd17734393;
    localparam logic [31:0] ETS  = 32'd1318966812;
    localparam int          TO   = 255;
    localparam int          MAXR = 3;
    localparam int          SD   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic        m_address, m_read, m_waitrequest;
    logic [31:0] m_readdata;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [3:0]  retries;
    logic [31:0] captured_id, captured_ts;

    logic        m_address2, m_read2, m_waitrequest2;
    logic [31:0] m_readdata2;
    logic        busy2, done2, pass2;
    logic [1:0]  fail_code2;
    logic [3:0]  retries2;
    logic [31:0] captured_id2, captured_ts2;
    logic        start2 = 1'b0;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    // slave for the default instance
    logic [31:0] id_val = EID;
    logic [31:0] ts_val = ETS;
    int          stall_cfg = 0;
    int          stall_used;
    bit          stuck = 1'b0;

    assign m_waitrequest = stuck || (stall_used < stall_cfg);
    assign m_readdata    = m_address ? ts_val : id_val;

    always @(posedge clk or posedge rst) begin
        if (rst) stall_used <= 0;
        else if (m_read && m_waitrequest) stall_used <= stall_used + 1;
    end

    // slave for the READ_LATENCY=2 instance: data is valid only two cycles after acceptance
    logic p1v, p2v, p1a, p2a;
    assign m_waitrequest2 = 1'b0;
    assign m_readdata2    = p2v ? (p2a ? ETS : EID) : 32'hDEADBEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1v <= 1'b0; p2v <= 1'b0; p1a <= 1'b0; p2a <= 1'b0;
        end else begin
            p1v <= m_read2 && !m_waitrequest2;
            p1a <= m_address2;
            p2v <= p1v;
            p2a <= p1a;
        end
    end

    sysid_checker dut (
        .clk(clk), .reset(rst), .start(start),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .retries(retries),
        .captured_id(captured_id), .captured_ts(captured_ts)
    );

    sysid_checker #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(rst), .start(start2),
        .m_address(m_address2), .m_read(m_read2), .m_waitrequest(m_waitrequest2), .m_readdata(m_readdata2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_code(fail_code2), .retries(retries2),
        .captured_id(captured_id2), .captured_ts(captured_ts2)
    );

    initial forever #5 clk = ~clk;

    // model of the default instance's current run
    int          rd_at   = SD;
    int          done_at = SD + 3;
    int          stalls  = 0;
    bit          to_mode = 1'b0;
    bit          exp_pass = 1'b1;
    logic [1:0]  exp_fc = 2'd0;
    logic [31:0] exp_id = EID;
    logic [31:0] exp_ts = ETS;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d", nm, got, exp, ecnt);
        end
    endtask

    task automatic set_model(input int rd, input int st, input bit tm, input bit p,
                             input logic [1:0] fc, input logic [31:0] i, input logic [31:0] t);
        rd_at    = rd;
        stalls   = st;
        to_mode  = tm;
        done_at  = tm ? rd + (MAXR + 1) * (TO + 1) : rd + 3 + st;
        exp_pass = p;
        exp_fc   = fc;
        exp_id   = i;
        exp_ts   = t;
    endtask

    task automatic wait_edge(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rerun(input bit p, input logic [1:0] fc, input logic [31:0] i, input logic [31:0] t);
        int c;
        c = ecnt;
        start = 1'b1;
        set_model(c + 1, 0, 1'b0, p, fc, i, t);
        @(negedge clk);
        start = 1'b0;
        wait_edge(c + 3);
        chk("rerun_not_yet_done", 64'(done), 64'd0);
        wait_edge(c + 4);
        chk("rerun_done", 64'(done), 64'd1);
        chk("rerun_fail_code", 64'(fail_code), 64'(fc));
        wait_edge(c + 8);
    endtask

    // per-cycle compare against the model
    initial begin
        int e, r;
        bit d, mr, ae, d2;
        forever begin
            @(posedge clk);
            if (rst) ecnt = 0;
            else ecnt = ecnt + 1;
            #1;
            if (rst) begin
                chk("reset_outs", 64'({busy, done, pass, fail_code, retries, m_read, m_address}), 64'b10000000000);
                chk("reset_capt", {captured_id, captured_ts}, 64'd0);
                chk("reset_outs2", 64'({busy2, done2, pass2, m_read2}), 64'b1000);
            end else begin
                e = ecnt;
                d = (e >= done_at);
                if (to_mode) begin
                    r  = (e >= rd_at) ? (e - rd_at) / (TO + 1) : 0;
                    if (r > MAXR) r = MAXR;
                    mr = (e >= rd_at) && !d && (((e - rd_at) % (TO + 1)) != TO);
                    ae = 1'b0;
                end else begin
                    r  = 0;
                    mr = (e >= rd_at) && (e < done_at - 1);
                    ae = (e >= rd_at + 1 + stalls);
                end
                chk("outs", 64'({busy, done, pass, fail_code, retries, m_read}),
                    64'({!d, d, d & exp_pass, d ? exp_fc : 2'd0, 4'(r), mr}));
                if (mr) chk("address", 64'(m_address), 64'(ae));
                if (d) chk("captured", {captured_id, captured_ts}, {exp_id, exp_ts});
                d2 = (e >= SD + 3 + 4);
                chk("outs2", 64'({busy2, done2, pass2, fail_code2, retries2}),
                    64'({!d2, d2, d2, 2'd0, 4'd0}));
                if (d2) chk("captured2", {captured_id2, captured_ts2}, {EID, ETS});
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog expired at edge %0d", ecnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // run 1: zero-wait, correct words; start pulses while busy are ignored
        set_model(SD, 0, 1'b0, 1'b1, 2'd0, EID, ETS);
        @(negedge clk);
        do_reset();
        wait_edge(4);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_edge(15);
        chk("delay_no_read", 64'(m_read), 64'd0);
        wait_edge(16);
        start = 1'b1;
        chk("rd_id_read", 64'({m_read, m_address}), 64'b10);
        @(negedge clk); start = 1'b0;
        wait_edge(18);
        chk("edge18_not_done", 64'({done, m_read}), 64'd0);
        wait_edge(19);
        chk("edge19_result", 64'({busy, done, pass, fail_code}), 64'b01100);
        chk("edge19_id", 64'(captured_id), 64'd17734393);
        chk("edge19_ts", 64'(captured_ts), 64'd1318966812);
        wait_edge(25);

        // reruns from DONE: bad timestamp, then bad ID and timestamp
        ts_val = 32'd0;
        rerun(1'b0, 2'd2, EID, 32'd0);
        chk("ts0_captured", 64'(captured_ts), 64'd0);
        id_val = 32'd1;
        rerun(1'b0, 2'd1, 32'd1, 32'd0);
        chk("bad_id_captured", 64'(captured_id), 64'd1);

        // five-cycle stall on the ID read
        id_val = EID; ts_val = ETS; stall_cfg = 5;
        set_model(SD, 5, 1'b0, 1'b1, 2'd0, EID, ETS);
        do_reset();
        wait_edge(21);
        chk("stall_hold", 64'({m_read, m_address}), 64'b10);
        wait_edge(23);
        chk("stall_not_done", 64'(done), 64'd0);
        wait_edge(24);
        chk("stall_done", 64'({done, pass, retries}), 64'b110000);
        wait_edge(28);

        // reset while the timestamp read is outstanding
        stall_cfg = 0;
        set_model(SD, 0, 1'b0, 1'b1, 2'd0, EID, ETS);
        do_reset();
        wait_edge(17);
        chk("in_rd_ts", 64'({m_read, m_address}), 64'b11);
        rst = 1'b1;
        #1;
        chk("async_reset_read", 64'({m_read, busy}), 64'b01);
        do_reset();
        wait_edge(19);
        chk("after_reset_pass", 64'({done, pass}), 64'b11);
        wait_edge(25);

        // slave never answers: four attempts, then timeout
        stuck = 1'b1;
        set_model(SD, 0, 1'b1, 1'b0, 2'd3, 32'd0, 32'd0);
        do_reset();
        wait_edge(271);
        chk("first_abort", 64'({m_read, retries}), 64'd0);
        wait_edge(272);
        chk("first_retry", 64'({m_read, m_address, retries}), 64'b1_0_0001);
        wait_edge(1039);
        chk("to_not_done", 64'(done), 64'd0);
        wait_edge(1040);
        chk("to_done", 64'({done, pass, fail_code, retries}), 64'b1_0_11_0011);
        wait_edge(1045);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
